// File: rtl/ysyx_22050078_imem_responder.sv
// Instruction-fetch responder: one outstanding fetch, fixed LATENCY, error flag for bad addresses.
// Define YSYX_22050078_IMEM_STATS_EN to add the stat_fetch / stat_err completion counters.
module ysyx_22050078_imem_responder #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INST_WIDTH-1:0] rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [INST_WIDTH-1:0] ld_data,
`ifdef YSYX_22050078_IMEM_STATS_EN
  output logic [31:0]           stat_fetch,
  output logic [31:0]           stat_err,
`endif
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid and its payload never change while valid is high and ready is low.

  localparam int                    DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4) << DEPTH_LOG2;
  localparam logic [3:0]            WAIT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rsp_valid;
  logic [INST_WIDTH-1:0] r_rsp_inst;
  logic                  r_rsp_err;
  logic [INST_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] w_samp_addr;
  logic [ADDR_WIDTH-1:0] w_samp_off;
  logic                  w_samp_err;
  logic [INST_WIDTH-1:0] w_samp_inst;
  logic [ADDR_WIDTH-1:0] w_ld_off;
  logic                  w_ld_ok;

  // Subtraction is in ADDR_WIDTH bits; the explicit below-base test stops wrapped offsets landing in range.
  assign w_samp_addr = (r_state == S_IDLE) ? req_addr : r_addr;
  assign w_samp_off  = w_samp_addr - BASE_ADDR;
  assign w_samp_err  = (w_samp_addr[1:0] != 2'b00) || (w_samp_addr < BASE_ADDR) || (w_samp_off >= SPAN);
  assign w_samp_inst = w_samp_err ? '0 : r_mem[w_samp_off[DEPTH_LOG2+1:2]];

  assign w_ld_off = ld_addr - BASE_ADDR;
  assign w_ld_ok  = ld_en && (ld_addr[1:0] == 2'b00) && (ld_addr >= BASE_ADDR) && (w_ld_off < SPAN);

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_inst  = r_rsp_inst;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

  // Non-blocking read in the FSM sees pre-load contents when a load hits the sampled word.
  always_ff @(posedge clk) begin
    if (w_ld_ok) r_mem[w_ld_off[DEPTH_LOG2+1:2]] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_inst  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_inst  <= w_samp_inst;
              r_rsp_err   <= w_samp_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_inst  <= w_samp_inst;
            r_rsp_err   <= w_samp_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef YSYX_22050078_IMEM_STATS_EN
  logic [31:0] r_stat_fetch;
  logic [31:0] r_stat_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_fetch <= '0;
      r_stat_err   <= '0;
    end else if (r_rsp_valid && rsp_ready) begin
      r_stat_fetch <= r_stat_fetch + 32'd1;
      if (r_rsp_err) r_stat_err <= r_stat_err + 32'd1;
    end
  end

  assign stat_fetch = r_stat_fetch;
  assign stat_err   = r_stat_err;
`endif

endmodule

// File: tb/tb_ysyx_22050078_imem_responder.sv
// Directed bench for the fetch responder: handshake timing, backpressure, errors, collisions, reset.
module tb_ysyx_22050078_imem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        ld_en;
  logic [63:0] ld_addr;
  logic [31:0] ld_data;
  logic [1:0]  dbg_state;
`ifdef YSYX_22050078_IMEM_STATS_EN
  logic [31:0] stat_fetch;
  logic [31:0] stat_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_fetch = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  ysyx_22050078_imem_responder #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
`ifdef YSYX_22050078_IMEM_STATS_EN
    .stat_fetch(stat_fetch),
    .stat_err  (stat_err),
`endif
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Full fetch; optionally loads hold_d into the same word during the first held cycle.
  task automatic fetch(input logic [63:0] a, input logic [31:0] ei, input logic ee,
                       input int hold, input logic hold_ld, input logic [31:0] hold_d);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0; req_addr = {$urandom, $urandom};
    chk("req_ready_busy", req_ready, 1'b0);
    for (int i = 1; i < LAT; i++) begin
      chk("rsp_valid_early", rsp_valid, 1'b0);
      tick();
    end
    chk("rsp_valid_rise", rsp_valid, 1'b1);
    chk("rsp_inst", rsp_inst, ei);
    chk("rsp_err", rsp_err, ee);
    chk("state_resp", dbg_state, 2'd2);
    for (int h = 0; h < hold; h++) begin
      if (h == 0 && hold_ld) begin ld_en = 1'b1; ld_addr = a; ld_data = hold_d; end
      tick();
      ld_en = 1'b0;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_inst", rsp_inst, ei);
      chk("hold_err", rsp_err, ee);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_fetch++;
    if (ee) exp_errs++;
    chk("rsp_valid_clear", rsp_valid, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Fill the store while in reset; misaligned and out-of-range loads must be dropped.
    load(64'h8000_0000, 32'h0000_0093);
    load(64'h8000_0010, 32'h1111_1111);
    load(64'h8000_0020, 32'h0000_0055);
    load(64'h8000_0022, 32'h0000_0066);
    load(64'h8000_3FFC, 32'hABCD_1234);
    load(64'h8000_4000, 32'hDEAD_BEEF);
    load(64'h7FFF_FFFC, 32'hDEAD_BEEF);

    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_inst", rsp_inst, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_state", dbg_state, 2'd0);
`ifdef YSYX_22050078_IMEM_STATS_EN
    chk("rst_stat_fetch", stat_fetch, 32'd0);
    chk("rst_stat_err", stat_err, 32'd0);
`endif
    rst = 1'b1;
    tick();

    fetch(64'h8000_0000, 32'h0000_0093, 1'b0, 0, 1'b0, 32'h0);
    fetch(64'h8000_0000, 32'h0000_0093, 1'b0, 5, 1'b0, 32'h0);
    fetch(64'h8000_0020, 32'h0000_0055, 1'b0, 0, 1'b0, 32'h0);

    fetch(64'h8000_0002, 32'h0, 1'b1, 1, 1'b0, 32'h0);
    fetch(64'h7FFF_FFFC, 32'h0, 1'b1, 0, 1'b0, 32'h0);
    fetch(64'h8000_4000, 32'h0, 1'b1, 0, 1'b0, 32'h0);
    fetch(64'h0000_0000, 32'h0, 1'b1, 0, 1'b0, 32'h0);
    fetch(64'h8000_3FFC, 32'hABCD_1234, 1'b0, 0, 1'b0, 32'h0);

    // Load lands on the same edge that samples the word: old data must be returned.
    req_valid = 1'b1; req_addr = 64'h8000_0010;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < LAT - 1; i++) tick();
    ld_en = 1'b1; ld_addr = 64'h8000_0010; ld_data = 32'h2222_2222;
    tick();
    ld_en = 1'b0;
    chk("coll_valid", rsp_valid, 1'b1);
    chk("coll_inst_old", rsp_inst, 32'h1111_1111);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_fetch++;
    fetch(64'h8000_0010, 32'h2222_2222, 1'b0, 2, 1'b1, 32'h3333_3333);
    fetch(64'h8000_0010, 32'h3333_3333, 1'b0, 0, 1'b0, 32'h0);

    // Reset one cycle after accept: the pending fetch must vanish.
    req_valid = 1'b1; req_addr = 64'h8000_0000;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    exp_fetch = 0; exp_errs = 0;
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_state", dbg_state, 2'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 1'b0);
    end

    fetch(64'h8000_0000, 32'h0000_0093, 1'b0, 0, 1'b0, 32'h0);
    fetch(64'h8000_3FFC, 32'hABCD_1234, 1'b0, 1, 1'b0, 32'h0);
    fetch(64'h8000_0020, 32'h0000_0055, 1'b0, 0, 1'b0, 32'h0);
    fetch(64'h8000_0001, 32'h0, 1'b1, 0, 1'b0, 32'h0);
`ifdef YSYX_22050078_IMEM_STATS_EN
    chk("stat_fetch", stat_fetch, 32'd4);
    chk("stat_err", stat_err, 32'd1);
`endif

    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("end_rst_valid", rsp_valid, 1'b0);
    chk("end_rst_inst", rsp_inst, 32'h0);
    chk("end_rst_req_ready", req_ready, 1'b1);
`ifdef YSYX_22050078_IMEM_STATS_EN
    chk("end_stat_fetch", stat_fetch, 32'd0);
    chk("end_stat_err", stat_err, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
